frame_arbiter: RTL

Frame-level arbiter that shares one feature-processing engine (e.g. the softmax stage) between two upstream requesters in the MNIST pipeline. It grants whole frames of FRAME_LEN beats to one requester at a time and records each frame's owner in a tag FIFO. The engine's result frames are routed back to the owning requester in issue order. It sits between the classifier front-ends and any single-instance stage.

---
 rtl/frame_arbiter_if.sv | 22 ++
 rtl/frame_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// frame_arbiter_if
//   One valid/ready/data beat stream. A beat moves on a cycle where valid and
//   ready are both high.
//   Signals:
//     valid  producer -> consumer  beat present
//     ready  consumer -> producer  beat can be taken
//     data   producer -> consumer  DATA_W-bit beat payload
//   Modports:
//     master  the producer side (drives valid/data, samples ready)
//     slave   the consumer side (samples valid/data, drives ready)
// -----------------------------------------------------------------------------
interface frame_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/frame_arbiter.sv
// -----------------------------------------------------------------------------
// frame_arbiter
//   Shares one processing engine between two requesters at frame granularity.
//   A whole frame of FRAME_LEN beats is granted to one requester, the owner is
//   pushed into a tag FIFO when the frame's last beat enters the engine, and
//   result beats coming back from the engine are steered to the owner at the
//   FIFO head. The head tag is popped after FRAME_LEN result beats.
//
//   Optional feature macro: FRAME_ARB_STRICT_PRIO_EN
//     defined   : fixed priority, requester 0 wins every tie
//     undefined : round-robin, the requester that did not own the previous
//                 frame wins a tie (requester 0 wins the first tie)
//
//   Ports:
//     clock       in   clock
//     reset_n     in   asynchronous active-low reset
//     req0, req1  slave   requester input streams
//     eng_in      master  stream into the engine
//     eng_out     slave   stream out of the engine
//     rsp0, rsp1  master  result streams back to the requesters
//     in_flight   out  frames issued to the engine and not yet fully returned
//     err_orphan  out  sticky: engine offered a beat while no tag was pending
// -----------------------------------------------------------------------------
module frame_arbiter #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 10,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  frame_arbiter_if.slave             req0,
  frame_arbiter_if.slave             req1,
  frame_arbiter_if.master            eng_in,
  frame_arbiter_if.slave             eng_out,
  frame_arbiter_if.master            rsp0,
  frame_arbiter_if.master            rsp1,
  output logic [$clog2(TAG_DEPTH):0] in_flight,
  output logic                       err_orphan
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(TAG_DEPTH);
  localparam logic [PTR_W:0]   OCC_EMPTY = (PTR_W + 1)'(0);

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  arb_state_e        state_r;
  arb_state_e        state_next_s;

  logic              grant_r;
  logic              win_s;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic [CNT_W-1:0]  ret_cnt_r;

  logic              tag_mem_r [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    occ_r;
  logic              err_orphan_r;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              grant_take_s;
  logic              eng_in_xfer_s;
  logic              ret_xfer_s;
  logic              push_s;
  logic              pop_s;
  logic              head_s;

  logic              eng_in_valid_s;
  logic [DATA_W-1:0] eng_in_data_s;
  logic              req0_ready_s;
  logic              req1_ready_s;
  logic              rsp0_valid_s;
  logic              rsp1_valid_s;
  logic              eng_out_ready_s;

`ifndef FRAME_ARB_STRICT_PRIO_EN
  logic              last_grant_r;
`endif

  assign fifo_full_s   = (occ_r == OCC_FULL);
  assign fifo_empty_s  = (occ_r == OCC_EMPTY);
  // A new frame is only started when a tag slot is free for it.
  assign grant_take_s  = (state_r == ARB_IDLE) && !fifo_full_s &&
                         (req0.valid || req1.valid);
  assign eng_in_xfer_s = eng_in_valid_s && eng_in.ready;
  assign push_s        = eng_in_xfer_s && (beat_cnt_r == BEAT_LAST);
  assign ret_xfer_s    = !fifo_empty_s && eng_out.valid && eng_out.ready;
  assign pop_s         = ret_xfer_s && (ret_cnt_r == BEAT_LAST);
  assign head_s        = tag_mem_r[rd_ptr_r];

  // Tie-break between the two requesters for the next frame.
  always_comb begin
`ifdef FRAME_ARB_STRICT_PRIO_EN
    if (req0.valid) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`else
    if (req0.valid && req1.valid) begin
      win_s = ~last_grant_r;
    end else if (req0.valid) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`endif
  end

  // Issue FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Issue FSM next-state logic: a frame ends only on its last accepted beat.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (grant_take_s) begin
          state_next_s = ARB_XFER;
        end else begin
          state_next_s = ARB_IDLE;
        end
      end
      ARB_XFER: begin
        if (push_s) begin
          state_next_s = ARB_IDLE;
        end else begin
          state_next_s = ARB_XFER;
        end
      end
      default: begin
        state_next_s = ARB_IDLE;
      end
    endcase
  end

  // Issue FSM outputs: connect the granted requester to the engine input.
  always_comb begin
    eng_in_valid_s = 1'b0;
    req0_ready_s   = 1'b0;
    req1_ready_s   = 1'b0;
    eng_in_data_s  = grant_r ? req1.data : req0.data;
    case (state_r)
      ARB_XFER: begin
        if (grant_r) begin
          eng_in_valid_s = req1.valid;
          req1_ready_s   = eng_in.ready;
        end else begin
          eng_in_valid_s = req0.valid;
          req0_ready_s   = eng_in.ready;
        end
      end
      default: begin
        eng_in_valid_s = 1'b0;
        req0_ready_s   = 1'b0;
        req1_ready_s   = 1'b0;
      end
    endcase
  end

  // Grant, round-robin history and beat counter of the frame being issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_r      <= 1'b0;
      beat_cnt_r   <= CNT_W'(0);
`ifndef FRAME_ARB_STRICT_PRIO_EN
      last_grant_r <= 1'b1;
`endif
    end else begin
      if (grant_take_s) begin
        grant_r <= win_s;
      end
      if (push_s) begin
        beat_cnt_r   <= CNT_W'(0);
`ifndef FRAME_ARB_STRICT_PRIO_EN
        last_grant_r <= grant_r;
`endif
      end else if (eng_in_xfer_s) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
    end
  end

  // Tag FIFO: owner of each issued frame, oldest at the read pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_r[i] <= 1'b0;
      end
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      occ_r    <= OCC_EMPTY;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant_r;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + (PTR_W + 1)'(1);
        2'b01:   occ_r <= occ_r - (PTR_W + 1)'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Return beat counter of the frame at the FIFO head.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ret_cnt_r <= CNT_W'(0);
    end else if (pop_s) begin
      ret_cnt_r <= CNT_W'(0);
    end else if (ret_xfer_s) begin
      ret_cnt_r <= ret_cnt_r + CNT_W'(1);
    end
  end

  // Sticky flag: engine offered a result while nothing was outstanding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_orphan_r <= 1'b0;
    end else if (fifo_empty_s && eng_out.valid) begin
      err_orphan_r <= 1'b1;
    end
  end

  // Return path: pass the engine stream straight through to the head owner.
  always_comb begin
    rsp0_valid_s    = 1'b0;
    rsp1_valid_s    = 1'b0;
    eng_out_ready_s = 1'b0;
    if (!fifo_empty_s) begin
      if (head_s) begin
        rsp1_valid_s    = eng_out.valid;
        eng_out_ready_s = rsp1.ready;
      end else begin
        rsp0_valid_s    = eng_out.valid;
        eng_out_ready_s = rsp0.ready;
      end
    end else begin
      rsp0_valid_s    = 1'b0;
      rsp1_valid_s    = 1'b0;
      eng_out_ready_s = 1'b0;
    end
  end

  assign eng_in.valid  = eng_in_valid_s;
  assign eng_in.data   = eng_in_data_s;
  assign req0.ready    = req0_ready_s;
  assign req1.ready    = req1_ready_s;
  assign rsp0.valid    = rsp0_valid_s;
  assign rsp1.valid    = rsp1_valid_s;
  assign rsp0.data     = eng_out.data;
  assign rsp1.data     = eng_out.data;
  assign eng_out.ready = eng_out_ready_s;
  assign in_flight     = occ_r;
  assign err_orphan    = err_orphan_r;

endmodule
